// File: rtl/fpga_top_lite_pkg.sv
// -----------------------------------------------------------------------------
// fpga_top_lite_pkg
// Shared constants and types for the behavioural FPGA fabric top.
//  - Array geometry: pad count, bit-line width, word-line count, LUT count.
//  - Row field offsets. A bit-line index is the bit position within a row.
//    Multi-bit fields place their LSB at the lowest index.
//  - lut_cfg_t, the decoded per-cell configuration, and decode_row().
// The geometry must keep CFG_W <= N_BL and N_LUT <= N_WL.
// -----------------------------------------------------------------------------
package fpga_top_lite_pkg;

    localparam int N_PAD     = 2304;
    localparam int N_BL      = 514;
    localparam int N_WL      = 407;
    localparam int N_LUT     = 8;
    localparam int PAD_IDX_W = $clog2(N_PAD);
    localparam int LUT_TT_W  = 16;

    localparam int VALID_O    = 0;
    localparam int REG_O      = 1;
    localparam int TT_O       = 2;
    localparam int SEL_BASE_O = TT_O + LUT_TT_W;
    localparam int OUT_O      = SEL_BASE_O + 4 * PAD_IDX_W;
    // Only the low CFG_W bits of a row carry meaning.
    localparam int CFG_W      = OUT_O + PAD_IDX_W;

    typedef logic [PAD_IDX_W-1:0] pad_idx_t;

    // Pad indices at or above this value address no pad.
    localparam pad_idx_t PAD_LIMIT = pad_idx_t'(N_PAD);

    typedef struct packed {
        logic                valid;
        logic                registered;
        logic [LUT_TT_W-1:0] tt;
        pad_idx_t [3:0]      sel;
        pad_idx_t            out_pad;
    } lut_cfg_t;

    function automatic int SEL_O(input int j);
        return SEL_BASE_O + j * PAD_IDX_W;
    endfunction

    function automatic lut_cfg_t decode_row(input logic [CFG_W-1:0] row);
        lut_cfg_t cfg;
        cfg            = '0;
        cfg.valid      = row[VALID_O];
        cfg.registered = row[REG_O];
        cfg.tt         = row[TT_O +: LUT_TT_W];
        for (int j = 0; j < 4; j++) begin
            cfg.sel[j] = row[SEL_O(j) +: PAD_IDX_W];
        end
        cfg.out_pad    = row[OUT_O +: PAD_IDX_W];
        return cfg;
    endfunction

endpackage

// File: rtl/fpga_top_lite_if.sv
// -----------------------------------------------------------------------------
// fpga_top_lite_if
// Pad ring and configuration-loader signals of the fabric top.
//  gfpga_pad_QL_PREIO_A2F      pad -> fabric inputs
//  gfpga_pad_QL_PREIO_F2A      fabric -> pad outputs
//  gfpga_pad_QL_PREIO_F2A_CLK  clock forwarded to pads fed by registered cells
//  bl_config_region_0          bit lines (row data)
//  wl_config_region_0          word lines (row select)
// master: pad ring / loader side.  slave: fabric side.
// -----------------------------------------------------------------------------
interface fpga_top_lite_if;
    import fpga_top_lite_pkg::*;

    logic [0:N_PAD-1] gfpga_pad_QL_PREIO_A2F;
    logic [0:N_PAD-1] gfpga_pad_QL_PREIO_F2A;
    logic [0:N_PAD-1] gfpga_pad_QL_PREIO_F2A_CLK;
    logic [0:N_BL-1]  bl_config_region_0;
    logic [0:N_WL-1]  wl_config_region_0;

    modport master (
        output gfpga_pad_QL_PREIO_A2F,
        output bl_config_region_0,
        output wl_config_region_0,
        input  gfpga_pad_QL_PREIO_F2A,
        input  gfpga_pad_QL_PREIO_F2A_CLK
    );

    modport slave (
        input  gfpga_pad_QL_PREIO_A2F,
        input  bl_config_region_0,
        input  wl_config_region_0,
        output gfpga_pad_QL_PREIO_F2A,
        output gfpga_pad_QL_PREIO_F2A_CLK
    );

endinterface

// File: rtl/fpga_lut4_cell.sv
// -----------------------------------------------------------------------------
// fpga_lut4_cell
// One LUT4 cell: four pad-selected inputs, 16-entry truth table and an
// optional output flip-flop.
//  clk        fabric clock
//  rst_n      async active-low clear of the flip-flop
//  scan_mode  1 holds the flip-flop
//  cfg        decoded configuration of this cell
//  a2f        pad inputs, bit p = pad p
//  cell_out   LUT result (combinational) or flip-flop value (registered)
// -----------------------------------------------------------------------------
module fpga_lut4_cell
    import fpga_top_lite_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             scan_mode,
    input  lut_cfg_t         cfg,
    input  logic [N_PAD-1:0] a2f,
    output logic             cell_out
);

    logic [3:0] lut_in_s;
    logic       lut_res_s;
    logic       ff_r;
    logic       unused_s;

    // Validity and destination are resolved by the pad arbiter.
    assign unused_s = cfg.valid ^ (^cfg.out_pad);

    // Input muxes; a selector beyond the last pad reads as 0.
    always_comb begin
        lut_in_s = 4'b0000;
        for (int j = 0; j < 4; j++) begin
            if (cfg.sel[j] < PAD_LIMIT) begin
                lut_in_s[j] = a2f[cfg.sel[j]];
            end else begin
                lut_in_s[j] = 1'b0;
            end
        end
    end

    // Truth-table lookup addressed by {in3,in2,in1,in0}.
    always_comb begin
        lut_res_s = cfg.tt[lut_in_s];
    end

    // Output flip-flop; it runs whatever the mode so reconfiguration keeps it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff_r <= 1'b0;
        end else if (scan_mode) begin
            ff_r <= ff_r;
        end else begin
            ff_r <= lut_res_s;
        end
    end

    // Select registered or zero-latency result.
    always_comb begin
        if (cfg.registered) begin
            cell_out = ff_r;
        end else begin
            cell_out = lut_res_s;
        end
    end

endmodule

// File: rtl/fpga_top_lite.sv
// -----------------------------------------------------------------------------
// fpga_top_lite
// Behavioural FPGA fabric top: configuration rows loaded over word/bit lines,
// an array of LUT4 cells, and pad arbitration (lowest valid cell wins a pad).
//  clk[0:15]      clk[0] is the fabric clock, the rest are unused
//  global_resetn  async active-low clear of cell flip-flops (not of config)
//  scan_en        no effect
//  scan_mode      1 freezes all cell flip-flops
//  io             pad ring and configuration lines (slave side)
// -----------------------------------------------------------------------------
module fpga_top_lite
    import fpga_top_lite_pkg::*;
(
    input  logic [0:15]           clk,
    input  logic                  global_resetn,
    input  logic                  scan_en,
    input  logic                  scan_mode,
    fpga_top_lite_if.slave        io
);

    logic [N_PAD-1:0] a2f_s;
    logic [CFG_W-1:0] bl_s;
    logic [CFG_W-1:0] cfg_row_r [N_LUT];
    lut_cfg_t         cfg_s     [N_LUT];
    logic [N_LUT-1:0] cell_out_s;
    logic [N_PAD-1:0] f2a_s;
    logic [N_PAD-1:0] f2a_reg_s;
    logic             hit_s;
    logic             unused_s;

    // Rows above the cell array and bits above the used row fields are inert.
    assign unused_s = ^{clk[1:15], scan_en,
                        io.bl_config_region_0[CFG_W:N_BL-1],
                        io.wl_config_region_0[N_LUT:N_WL-1]};

    // Re-index the ascending port buses so internal bit b is line/pad b.
    always_comb begin
        a2f_s = '0;
        bl_s  = '0;
        for (int p = 0; p < N_PAD; p++) begin
            a2f_s[p] = io.gfpga_pad_QL_PREIO_A2F[p];
        end
        for (int b = 0; b < CFG_W; b++) begin
            bl_s[b] = io.bl_config_region_0[b];
        end
    end

    // Configuration rows: every selected row takes the bit lines; never reset.
    always_ff @(posedge clk[0]) begin
        for (int r = 0; r < N_LUT; r++) begin
            if (io.wl_config_region_0[r]) begin
                cfg_row_r[r] <= bl_s;
            end else begin
                cfg_row_r[r] <= cfg_row_r[r];
            end
        end
    end

    for (genvar i = 0; i < N_LUT; i++) begin : g_cell
        assign cfg_s[i] = decode_row(cfg_row_r[i]);

        fpga_lut4_cell u_cell (
            .clk       (clk[0]),
            .rst_n     (global_resetn),
            .scan_mode (scan_mode),
            .cfg       (cfg_s[i]),
            .a2f       (a2f_s),
            .cell_out  (cell_out_s[i])
        );
    end

    // Pad arbitration: walk from the highest cell down so the lowest wins.
    always_comb begin
        f2a_s     = '0;
        f2a_reg_s = '0;
        hit_s     = 1'b0;
        for (int i = N_LUT - 1; i >= 0; i--) begin
            hit_s = cfg_s[i].valid && (cfg_s[i].out_pad < PAD_LIMIT);
            if (hit_s) begin
                f2a_s[cfg_s[i].out_pad]     = cell_out_s[i];
                f2a_reg_s[cfg_s[i].out_pad] = cfg_s[i].registered;
            end else begin
                // this cell drives no pad
            end
        end
    end

    // Pad drivers; the clock is forwarded only where a registered cell wins.
    always_comb begin
        io.gfpga_pad_QL_PREIO_F2A     = '0;
        io.gfpga_pad_QL_PREIO_F2A_CLK = '0;
        for (int p = 0; p < N_PAD; p++) begin
            io.gfpga_pad_QL_PREIO_F2A[p]     = f2a_s[p];
            io.gfpga_pad_QL_PREIO_F2A_CLK[p] = f2a_reg_s[p] & clk[0];
        end
    end

endmodule

// File: tb/tb_fpga_top_lite.sv
// -----------------------------------------------------------------------------
// tb_fpga_top_lite
// Self-checking bench for fpga_top_lite. Cells are described as plain records
// (valid, registered, truth table, integer selectors, integer output pad);
// rows are packed from those records and the expected pad state is derived
// from the records, the driven pad inputs and a per-cell flip-flop value.
// -----------------------------------------------------------------------------
module tb_fpga_top_lite;

    localparam int NP  = 2304;
    localparam int NBL = 514;
    localparam int NWL = 407;
    localparam int NL  = 8;
    localparam int W   = $clog2(NP);

    typedef struct {
        bit        valid;
        bit        regd;
        bit [15:0] tt;
        int        sel [4];
        int        outp;
    } cell_m_t;

    logic        clk0;
    logic [0:15] clk_bus;
    logic        rstn;
    logic        scan_en;
    logic        scan_mode;

    assign clk_bus = {clk0, 15'b0};

    fpga_top_lite_if bus ();

    fpga_top_lite dut (
        .clk           (clk_bus),
        .global_resetn (rstn),
        .scan_en       (scan_en),
        .scan_mode     (scan_mode),
        .io            (bus)
    );

    int      n_cmp;
    int      n_bad;
    cell_m_t cfg_m [NL];
    bit      ff_m  [NL];
    cell_m_t row_m;
    bit      av [7];
    bit      bv [7];

    function automatic cell_m_t mk(bit valid, bit regd, bit [15:0] tt,
                                   int s0, int s1, int s2, int s3, int outp);
        cell_m_t c;
        c.valid  = valid;
        c.regd   = regd;
        c.tt     = tt;
        c.sel[0] = s0;
        c.sel[1] = s1;
        c.sel[2] = s2;
        c.sel[3] = s3;
        c.outp   = outp;
        return c;
    endfunction

    function automatic int rand_idx(int lim_small, int n_small);
        int v;
        v = int'($urandom_range(0, n_small + 1));
        if (v < n_small) return v % lim_small;
        if (v == n_small) return NP;
        return (1 << W) - 1;
    endfunction

    function automatic cell_m_t rand_cell();
        cell_m_t c;
        c.valid = ($urandom_range(0, 3) != 0);
        c.regd  = 1'($urandom_range(0, 1));
        c.tt    = 16'($urandom);
        for (int j = 0; j < 4; j++) c.sel[j] = rand_idx(8, 8);
        c.outp  = rand_idx(16, 16);
        return c;
    endfunction

    // Row image: bit-line index = bit position, fields LSB first.
    function automatic logic [0:NBL-1] pack(cell_m_t c);
        logic [0:NBL-1] v;
        int s;
        v    = '0;
        v[0] = c.valid;
        v[1] = c.regd;
        for (int k = 0; k < 16; k++) v[2 + k] = c.tt[k];
        for (int j = 0; j < 4; j++) begin
            s = c.sel[j];
            for (int k = 0; k < W; k++) v[18 + j * W + k] = s[k];
        end
        s = c.outp;
        for (int k = 0; k < W; k++) v[18 + 4 * W + k] = s[k];
        for (int b = 18 + 5 * W; b < NBL; b++) v[b] = 1'($urandom_range(0, 1));
        return v;
    endfunction

    function automatic bit pad_in(int s);
        if (s < NP) return bus.gfpga_pad_QL_PREIO_A2F[s];
        return 1'b0;
    endfunction

    function automatic bit lut_val(int i);
        int idx;
        idx = 0;
        for (int j = 0; j < 4; j++) if (pad_in(cfg_m[i].sel[j])) idx += (1 << j);
        return cfg_m[i].tt[idx];
    endfunction

    // Lowest-index valid cell aimed at pad p, or -1.
    function automatic int winner(int p);
        for (int i = 0; i < NL; i++) begin
            if (cfg_m[i].valid && cfg_m[i].outp == p) return i;
        end
        return -1;
    endfunction

    function automatic int first_diff(logic [0:NP-1] a, logic [0:NP-1] b);
        for (int p = 0; p < NP; p++) if (a[p] !== b[p]) return p;
        return 0;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_pads(string tag);
        logic [0:NP-1] ef;
        logic [0:NP-1] ec;
        int w;
        int bp;
        for (int p = 0; p < NP; p++) begin
            w     = winner(p);
            ef[p] = (w < 0) ? 1'b0 : (cfg_m[w].regd ? ff_m[w] : lut_val(w));
            ec[p] = (w >= 0) && cfg_m[w].regd && clk0;
        end
        n_cmp++;
        assert (bus.gfpga_pad_QL_PREIO_F2A === ef) else begin
            n_bad++;
            bp = first_diff(bus.gfpga_pad_QL_PREIO_F2A, ef);
            $error("FAIL %s_f2a: pad %0d observed %0b expected %0b",
                   tag, bp, bus.gfpga_pad_QL_PREIO_F2A[bp], ef[bp]);
        end
        n_cmp++;
        assert (bus.gfpga_pad_QL_PREIO_F2A_CLK === ec) else begin
            n_bad++;
            bp = first_diff(bus.gfpga_pad_QL_PREIO_F2A_CLK, ec);
            $error("FAIL %s_f2a_clk: pad %0d observed %0b expected %0b",
                   tag, bp, bus.gfpga_pad_QL_PREIO_F2A_CLK[bp], ec[bp]);
        end
    endtask

    // One clk[0] period; the reference is advanced to its post-edge state.
    task automatic tick(string tag);
        bit nxt [NL];
        for (int i = 0; i < NL; i++) begin
            nxt[i] = (rstn && !scan_mode) ? lut_val(i) : ff_m[i];
        end
        for (int r = 0; r < NL; r++) begin
            if (bus.wl_config_region_0[r]) cfg_m[r] = row_m;
        end
        ff_m = nxt;
        clk0 = 1'b1;
        #2;
        chk_pads({tag, "_hi"});
        #3;
        clk0 = 1'b0;
        #5;
        chk_pads({tag, "_lo"});
    endtask

    task automatic drive_row(cell_m_t c, logic [NL-1:0] rows);
        row_m = c;
        bus.bl_config_region_0 = pack(c);
        bus.wl_config_region_0 = '0;
        for (int r = 0; r < NL; r++) if (rows[r]) bus.wl_config_region_0[r] = 1'b1;
        tick("cfg");
        bus.wl_config_region_0 = '0;
    endtask

    task automatic rand_pads();
        for (int p = 0; p < NP; p++) bus.gfpga_pad_QL_PREIO_A2F[p] = 1'($urandom_range(0, 1));
    endtask

    task automatic set_ab(bit a, bit b);
        bus.gfpga_pad_QL_PREIO_A2F[0] = a;
        bus.gfpga_pad_QL_PREIO_A2F[1] = b;
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        clk0      = 1'b0;
        rstn      = 1'b0;
        scan_en   = 1'b0;
        scan_mode = 1'b0;
        bus.gfpga_pad_QL_PREIO_A2F = '0;
        bus.bl_config_region_0     = '0;
        bus.wl_config_region_0     = '0;
        for (int i = 0; i < NL; i++) begin
            cfg_m[i] = mk(1'b0, 1'b0, 16'h0000, 0, 0, 0, 0, 0);
            ff_m[i]  = 1'b0;
        end
        av = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        bv = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        // Reset state and unconfigured fabric.
        #5;
        chk_pads("reset");
        rstn = 1'b1;
        #5;
        for (int t = 0; t < 4; t++) begin
            rand_pads();
            #1;
            chk("unconf_f2a_or", 32'(|bus.gfpga_pad_QL_PREIO_F2A), 32'd0);
            tick("unconf");
        end
        bus.gfpga_pad_QL_PREIO_A2F = '0;

        // and2, combinational, on pads a=0 b=1 c=2.
        drive_row(mk(1'b1, 1'b0, 16'h8888, 0, 1, NP, NP, 2), 8'h01);
        for (int s = 0; s < 7; s++) begin
            set_ab(av[s], bv[s]);
            #5;
            chk("and2_c", 32'(bus.gfpga_pad_QL_PREIO_F2A[2]), 32'(av[s] & bv[s]));
            chk("and2_clk", 32'(bus.gfpga_pad_QL_PREIO_F2A_CLK[2]), 32'd0);
        end
        chk_pads("and2");

        // and2, registered: one-cycle latency, forwarded clock, async clear.
        set_ab(1'b0, 1'b0);
        drive_row(mk(1'b1, 1'b1, 16'h8888, 0, 1, NP, NP, 2), 8'h01);
        set_ab(1'b1, 1'b1);
        #1;
        chk("reg_before_edge", 32'(bus.gfpga_pad_QL_PREIO_F2A[2]), 32'd0);
        tick("reg");
        chk("reg_after_edge", 32'(bus.gfpga_pad_QL_PREIO_F2A[2]), 32'd1);
        chk("reg_clk_low", 32'(bus.gfpga_pad_QL_PREIO_F2A_CLK[2]), 32'd0);
        rstn = 1'b0;
        for (int i = 0; i < NL; i++) ff_m[i] = 1'b0;
        #1;
        chk("reg_reset_c", 32'(bus.gfpga_pad_QL_PREIO_F2A[2]), 32'd0);
        tick("reg_in_reset");
        rstn = 1'b1;
        #1;
        tick("reg_release");
        chk("reg_relearn", 32'(bus.gfpga_pad_QL_PREIO_F2A[2]), 32'd1);

        // Scan freeze: flop holds 1 while inputs go to 0.
        scan_mode = 1'b1;
        set_ab(1'b0, 1'b1);
        for (int t = 0; t < 5; t++) begin
            tick("scan");
            chk("scan_hold", 32'(bus.gfpga_pad_QL_PREIO_F2A[2]), 32'd1);
        end
        scan_mode = 1'b0;
        tick("scan_off");
        chk("scan_release", 32'(bus.gfpga_pad_QL_PREIO_F2A[2]), 32'd0);

        // Conflict on pad 5: cell 0 wins.
        drive_row(mk(1'b0, 1'b0, 16'h0000, 0, 0, 0, 0, 0), 8'hFF);
        drive_row(mk(1'b1, 1'b0, 16'hFFFF, NP, NP, NP, NP, 5), 8'h01);
        drive_row(mk(1'b1, 1'b0, 16'h0000, NP, NP, NP, NP, 5), 8'h02);
        #1;
        chk("conflict_pad5", 32'(bus.gfpga_pad_QL_PREIO_F2A[5]), 32'd1);
        drive_row(mk(1'b0, 1'b0, 16'h0000, 0, 0, 0, 0, 0), 8'h01);
        chk("conflict_cell1", 32'(bus.gfpga_pad_QL_PREIO_F2A[5]), 32'd0);

        // Two word lines, one row image; then drop row 0 and row 1 remains.
        drive_row(mk(1'b0, 1'b0, 16'h0000, 0, 0, 0, 0, 0), 8'hFF);
        drive_row(mk(1'b1, 1'b0, 16'h6666, 0, 1, NP, NP, 7), 8'h03);
        for (int s = 0; s < 4; s++) begin
            set_ab(s[0], s[1]);
            #1;
            chk("multiwl_xor", 32'(bus.gfpga_pad_QL_PREIO_F2A[7]), 32'(s[0] ^ s[1]));
        end
        drive_row(mk(1'b0, 1'b0, 16'h0000, 0, 0, 0, 0, 0), 8'h01);
        for (int s = 0; s < 4; s++) begin
            set_ab(s[0], s[1]);
            #1;
            chk("multiwl_row1", 32'(bus.gfpga_pad_QL_PREIO_F2A[7]), 32'(s[0] ^ s[1]));
        end

        // Random configurations and pad inputs; the first set loads in reset.
        for (int c = 0; c < 12; c++) begin
            if (c == 0) begin
                rstn = 1'b0;
                for (int i = 0; i < NL; i++) ff_m[i] = 1'b0;
            end
            for (int r = 0; r < NL; r++) drive_row(rand_cell(), 8'(1 << r));
            rstn = 1'b1;
            #1;
            for (int t = 0; t < 10; t++) begin
                for (int p = 0; p < 8; p++) bus.gfpga_pad_QL_PREIO_A2F[p] = 1'($urandom_range(0, 1));
                scan_mode = ($urandom_range(0, 3) == 0);
                #1;
                chk_pads("rand_comb");
                tick("rand");
            end
            scan_mode = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fpga_top_lite.md
Name: fpga_top_lite

Overview:
- Compact behavioural model of the FPGA fabric top, used for bitstream-level simulation of small mapped designs (e.g. and2).
- Configuration is loaded through a memory-bank interface: word lines select rows, bit lines carry row data.
- A configured array of LUT4 cells reads A2F pads and drives F2A pads, each output combinational or registered.
- Sits at chip top, between the pad ring (gfpga_pad_*) and the configuration loader.

Parameters:
- N_PAD, 2304, number of pads in each gfpga_pad_* bus.
- N_BL, 514, bit-line width, which is the configuration row width.
- N_WL, 407, word-line count, which is the number of configuration rows.
- N_LUT, 8, number of LUT4 cells; cell i is configured from row i. Requires N_LUT <= N_WL.
- PAD_IDX_W, $clog2(N_PAD), width of a pad-index field.

Ports:
- clk  in  [0:15]  clock bus; clk[0] is the single fabric clock; clk[1..15] are unused and tied 0 at top.
- global_resetn  in  1  asynchronous active-low reset.
- scan_en  in  1  scan enable; no effect in this version.
- scan_mode  in  1  scan mode; 1 freezes all LUT flip-flops.
- gfpga_pad_QL_PREIO_A2F  in  [0:N_PAD-1]  pad-to-fabric inputs.
- gfpga_pad_QL_PREIO_F2A  out  [0:N_PAD-1]  fabric-to-pad outputs.
- gfpga_pad_QL_PREIO_F2A_CLK  out  [0:N_PAD-1]  clock forwarded to pads that are driven by registered cells.
- bl_config_region_0  in  [0:N_BL-1]  bit lines (row data).
- wl_config_region_0  in  [0:N_WL-1]  word lines (row select).

Behaviour:

Clocking and reset:
- One clock domain: clk[0], rising edge.
- Reset is asynchronous and active-low on global_resetn.

Configuration memory (N_WL x N_BL bits):
- On each rising clk[0], every row r with wl[r]=1 loads the bl vector.
- Several word lines high at once write the same data to all selected rows.
- global_resetn does NOT clear configuration. Power-up contents are 0, so all cells are invalid.
- Configuration may be loaded while reset is asserted.

Row layout for cell i (row i); bl index = bit position; multi-bit fields are LSB at the lowest index:
- [0] valid.
- [1] registered.
- [2+k] truth-table bit k, for k = 0..15.
- [18 +: W] sel0, [18+W +: W] sel1, [18+2W +: W] sel2, [18+3W +: W] sel3.
- [18+4W +: W] out_pad.
- W = PAD_IDX_W. The layout requires N_BL >= 18+5W; defaults give 78.

LUT cell:
- Input inj = A2F[selj]. inj = 0 if selj >= N_PAD.
- Combinational result = truth_table[{in3,in2,in1,in0}].
- registered=0: the result goes to the pad with zero latency.
- registered=1: a flip-flop on clk[0] captures the result, giving 1-cycle latency.
  - The flip-flop is cleared asynchronously to 0 by global_resetn=0.
  - It holds its value while scan_mode=1.

Pad outputs:
- F2A[p] = output of the lowest-index valid cell with out_pad == p; otherwise 0.
- out_pad >= N_PAD drives nothing.
- F2A_CLK[p] = clk[0] if that winning cell is registered; otherwise 0.

Reset values:
- All flip-flops are 0.
- Outputs are then a pure function of configuration and A2F: registered pads read 0, combinational pads stay live during reset.

Reconfiguration:
- Rewriting a row takes effect from the next clk[0] rising edge.
- A cell's flip-flop keeps its value across reconfiguration.

Decomposition:
- Package fpga_top_lite_pkg holds:
  - field offset constants (VALID_O, REG_O, TT_O, SEL_O(j), OUT_O);
  - the LUT_TT_W=16 constant;
  - a lut_cfg_t struct {valid, registered, tt[15:0], sel[4], out_pad} and a decode function row -> lut_cfg_t.
- One sub-module, fpga_lut4_cell: input muxing, LUT, optional flip-flop.
- The top holds the configuration array, the generate loop over cells, and pad arbitration.

Test Plan:
- and2 combinational: cell0 = valid, registered=0, tt=0x8888, sel0=pad 0 (a), sel1=pad 1 (b), sel2=sel3=N_PAD, out_pad=2 (c). Release reset and sweep (a,b) = 00, 01, 10, 11, 01, 10, 11 at 5 ns steps. Required c = 0, 0, 0, 1, 0, 0, 1 within each step. F2A_CLK[2]=0.
- Registered cell: same as the and2 case with registered=1. With a=b=1, c rises only after the next clk[0] edge; F2A_CLK[2] toggles with clk[0]. Asserting global_resetn=0 mid-run forces c=0 immediately.
- Unconfigured fabric: no rows written. Every F2A=0 and every F2A_CLK=0 for any A2F.
- Conflict: cells 0 and 1 both target pad 5, tt0=0xFFFF, tt1=0x0000. Required F2A[5]=1 (cell 0 wins).
- Scan freeze: registered cell holding 1, scan_mode=1, then the inputs change. The flip-flop stays 1 for 5 cycles and updates after scan_mode=0.
- Multi-word-line write: wl[0] and wl[1] high with one bl vector. Rows 0 and 1 become identical, and both cells drive the same pad; cell 0 wins.
